// File: rtl/rps_match_pkg.sv
// Shared encodings for the rock-paper-scissors match controller.
// Move, round-result and FSM state types used by the top and the judge.
package rps_pkg;

    typedef enum logic [1:0] {
        ROCK     = 2'b00,
        PAPER    = 2'b01,
        SCISSORS = 2'b10,
        INVALID  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        P1WIN = 2'b01,
        P2WIN = 2'b10,
        TIE   = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_MOVE = 2'b01,
        RESOLVE   = 2'b10,
        DONE      = 2'b11
    } state_t;

endpackage

// File: rtl/rps_match_if.sv
// Move-pair handshake between the player capture logic and the match controller.
interface rps_match_if;
    logic [1:0] move1;
    logic [1:0] move2;
    logic       move_valid;
    logic       move_ready;

    modport master (output move1, output move2, output move_valid, input move_ready);
    modport slave  (input move1, input move2, input move_valid, output move_ready);
endinterface

// File: rtl/rps_match_judge.sv
// Combinational round judge: NONE when either move is invalid.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] move1,
    input  logic [1:0] move2,
    output logic [1:0] result
);

    always_comb begin
        result = NONE;
        if (move1 == INVALID || move2 == INVALID) begin
            result = NONE;
        end else if (move1 == move2) begin
            result = TIE;
        end else begin
            case ({move1, move2})
                {PAPER, ROCK},
                {ROCK, SCISSORS},
                {SCISSORS, PAPER}: result = P1WIN;
                default:           result = P2WIN;
            endcase
        end
    end

endmodule

// File: rtl/rps_match.sv
// Best-of-N rock-paper-scissors match controller: takes one move pair per round,
// judges it, keeps scores and declares a winner on first-to-target or round limit.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_MOVE | match running, move_ready high
// RESOLVE   | one cycle, judging the registered pair
// DONE      | match decided, outputs held until start
module rps_match
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int RND_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    rps_match_if.slave         mv,
    output logic [1:0]         round_result,
    output logic               round_valid,
    output logic               move_err,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] ties,
    output logic [RND_W-1:0]   round_cnt,
    output logic               busy,
    output logic               match_done,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
    localparam logic [RND_W-1:0]   MAX_R = RND_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic [1:0]         mv1_q, mv2_q;
    logic [1:0]         res;
    logic               ready;
    logic               take;
    logic [SCORE_W-1:0] s1_n, s2_n, t_n;
    logic [RND_W-1:0]   rnd_n;
    logic               match_end;
    logic [1:0]         win_d;

    rps_judge u_judge (
        .move1  (mv1_q),
        .move2  (mv2_q),
        .result (res)
    );

    assign mv.move_ready = ready;
    assign take = (state_q == WAIT_MOVE) && mv.move_valid && !start;

    // Post-increment values; the end condition is evaluated on these.
    always_comb begin
        s1_n  = score1    + SCORE_W'(res == P1WIN);
        s2_n  = score2    + SCORE_W'(res == P2WIN);
        t_n   = ties      + SCORE_W'(res == TIE);
        rnd_n = round_cnt + RND_W'(res != NONE);
        match_end = (s1_n == WIN_T) || (s2_n == WIN_T) || (rnd_n == MAX_R);
        if (s1_n == WIN_T)      win_d = P1WIN;
        else if (s2_n == WIN_T) win_d = P2WIN;
        else if (s1_n > s2_n)   win_d = P1WIN;
        else if (s2_n > s1_n)   win_d = P2WIN;
        else                    win_d = TIE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        busy       = 1'b0;
        match_done = 1'b0;
        case (state_q)
            IDLE: ;
            WAIT_MOVE: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (mv.move_valid) state_d = RESOLVE;
            end
            RESOLVE: begin
                busy = 1'b1;
                if (res != NONE && match_end) state_d = DONE;
                else                          state_d = WAIT_MOVE;
            end
            DONE: match_done = 1'b1;
            default: state_d = IDLE;
        endcase
        // start aborts from any state and also blocks a same-cycle handshake
        if (start) state_d = WAIT_MOVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv1_q        <= 2'b00;
            mv2_q        <= 2'b00;
            round_result <= NONE;
            round_valid  <= 1'b0;
            move_err     <= 1'b0;
            score1       <= '0;
            score2       <= '0;
            ties         <= '0;
            round_cnt    <= '0;
            winner       <= NONE;
        end else begin
            round_valid <= 1'b0;
            move_err    <= 1'b0;
            if (start) begin
                round_result <= NONE;
                score1       <= '0;
                score2       <= '0;
                ties         <= '0;
                round_cnt    <= '0;
                winner       <= NONE;
            end else begin
                if (take) begin
                    mv1_q <= mv.move1;
                    mv2_q <= mv.move2;
                end
                if (state_q == RESOLVE) begin
                    if (res == NONE) begin
                        move_err <= 1'b1;
                    end else begin
                        round_result <= res;
                        score1       <= s1_n;
                        score2       <= s2_n;
                        ties         <= t_n;
                        round_cnt    <= rnd_n;
                        round_valid  <= 1'b1;
                        if (match_end) winner <= win_d;
                    end
                end
            end
        end
    end

    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        (state_q == RESOLVE && !start) |->
            !((res == P1WIN && score1 == '1) || (res == P2WIN && score2 == '1) ||
              (res == TIE && ties == '1) || (res != NONE && round_cnt == '1)));

endmodule

// File: tb/tb_rps_match.sv
// Scoreboard bench for rps_match: expected round records are queued at handshake
// and compared whenever the DUT pulses round_valid.
module tb_rps_match;

    localparam int WIN = 3;
    localparam int MAXR = 9;

    typedef struct {
        logic [1:0] res;
        int         s1, s2, t, rc;
        logic [1:0] win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] round_result, winner;
    logic       round_valid, move_err, busy, match_done;
    logic [3:0] score1, score2, ties, round_cnt;

    rps_match_if bus ();

    rps_match #(.WIN_TARGET(WIN), .MAX_ROUNDS(MAXR), .SCORE_W(4), .RND_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mv           (bus.slave),
        .round_result (round_result),
        .round_valid  (round_valid),
        .move_err     (move_err),
        .score1       (score1),
        .score2       (score2),
        .ties         (ties),
        .round_cnt    (round_cnt),
        .busy         (busy),
        .match_done   (match_done),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    int         m_s1, m_s2, m_t, m_rc;
    logic [1:0] m_win;
    logic       m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_t = 0; m_rc = 0;
        m_win = 2'b00; m_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, bus.move_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, match_done, 0);
        check({tag, "_rv"}, round_valid, 0);
        check({tag, "_err"}, move_err, 0);
        check({tag, "_cnts"}, {score1, score2, ties, round_cnt}, 0);
        check({tag, "_res_win"}, {round_result, winner}, 0);
    endtask

    // Handshake one pair, update the model, check latency and the ready return.
    task automatic play(input logic [1:0] a, input logic [1:0] b);
        int   n;
        int   d;
        exp_t e;
        logic valid;
        n = 0;
        while (!bus.move_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", bus.move_ready, 1);
        bus.move1 = a;
        bus.move2 = b;
        bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        valid = (a != 2'b11) && (b != 2'b11);
        if (valid) begin
            d = (int'(a) - int'(b) + 3) % 3;
            if (d == 1)      begin m_s1++; e.res = 2'b01; end
            else if (d == 2) begin m_s2++; e.res = 2'b10; end
            else             begin m_t++;  e.res = 2'b11; end
            m_rc++;
            if (m_s1 == WIN)                 begin m_win = 2'b01; m_done = 1'b1; end
            else if (m_s2 == WIN)            begin m_win = 2'b10; m_done = 1'b1; end
            else if (m_rc == MAXR) begin
                m_done = 1'b1;
                m_win = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b11;
            end
            e.s1 = m_s1; e.s2 = m_s2; e.t = m_t; e.rc = m_rc; e.win = m_win;
            sb_q.push_back(e);
        end
        check("resolve_ready", bus.move_ready, 0);
        check("resolve_rv", round_valid, 0);
        tick();
        if (valid) begin
            check("latency_rv", round_valid, 1);
            check("no_err", move_err, 0);
        end else begin
            check("err_pulse", move_err, 1);
            check("err_rv", round_valid, 0);
            check("err_cnts", {score1, score2, ties, round_cnt},
                  {4'(m_s1), 4'(m_s2), 4'(m_t), 4'(m_rc)});
        end
        check("ready_back", bus.move_ready, !m_done);
        check("done_lvl", match_done, m_done);
    endtask

    always @(negedge clk) begin
        if (round_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rv", 0, 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", round_result, e.res);
                check("sb_score1", score1, e.s1);
                check("sb_score2", score2, e.s2);
                check("sb_ties", ties, e.t);
                check("sb_round_cnt", round_cnt, e.rc);
                check("sb_winner", winner, e.win);
            end
        end
    end

    localparam logic [1:0] R = 2'b00, P = 2'b01, S = 2'b10, X = 2'b11;

    initial begin
        bus.move1 = 2'b00;
        bus.move2 = 2'b00;
        bus.move_valid = 1'b0;
        model_clear();

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("reset");

        // first to three: paper beats rock
        do_start();
        check("start_busy", busy, 1);
        check("start_ready", bus.move_ready, 1);
        for (int i = 0; i < 3; i++) play(P, R);
        check("p1_winner", winner, 2'b01);
        check("p1_rounds", round_cnt, 3);
        check("p1_busy", busy, 0);
        tick(); tick(); tick();
        check("done_hold", {match_done, winner, score1}, {1'b1, 2'b01, 4'd3});
        check("done_ready", bus.move_ready, 0);

        // nine ties
        do_start();
        check("restart_clear", {score1, round_cnt, winner}, 0);
        for (int i = 0; i < 9; i++) play(R, R);
        check("tie_winner", winner, 2'b11);
        check("tie_count", ties, 9);
        check("tie_scores", {score1, score2}, 0);

        // round limit with P1 ahead 2-1, six ties
        begin
            logic [1:0] seq1 [9];
            logic [1:0] seq2 [9];
            seq1 = '{S, P, S, R, S, S, P, S, S};
            seq2 = '{S, R, S, P, S, S, R, S, S};
            do_start();
            for (int i = 0; i < 9; i++) play(seq1[i], seq2[i]);
            check("mix_winner", winner, 2'b01);
            check("mix_scores", {score1, score2, ties}, {4'd2, 4'd1, 4'd6});
        end

        // invalid pairs
        do_start();
        play(P, S);
        play(X, R);
        play(R, X);
        check("inv_result_hold", round_result, 2'b10);

        // abort during RESOLVE with score1 at 2
        do_start();
        play(P, R);
        play(S, P);
        check("abort_pre", score1, 2);
        bus.move1 = P; bus.move2 = R; bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        check("abort_cnts", {score1, score2, ties, round_cnt}, 0);
        check("abort_ready", bus.move_ready, 1);
        check("abort_rv", round_valid, 0);
        tick();
        check("abort_no_rv", {round_valid, move_err}, 0);

        // start and move_valid together: move is dropped
        bus.move1 = P; bus.move2 = R; bus.move_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.move_valid = 1'b0;
        check("collide_ready", bus.move_ready, 1);
        tick(); tick();
        check("collide_no_round", {round_valid, round_cnt}, 0);

        // reset mid-match with score2 at 2
        play(R, P);
        play(S, R);
        check("rst_pre", score2, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check_reset_vals("midrst");
        tick(); tick(); tick();
        check("idle_ready", bus.move_ready, 0);
        do_start();
        play(R, S);
        tick(); tick();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rps_match.md
Name: rps_match

Overview:
- Parametrised best-of-N rock-paper-scissors match controller.
- Accepts one move pair per round through a valid/ready handshake and judges each round.
- Keeps per-player and tie counters, and declares a match winner on first-to-WIN_TARGET or on MAX_ROUNDS exhaustion.
- Sits between the player input capture logic and the score display/LED driver.

Parameters:
- WIN_TARGET, 3, round wins needed to take the match (>=1).
- MAX_ROUNDS, 9, hard round limit including ties (>= 2*WIN_TARGET-1).
- SCORE_W, 4, width of the score/tie counters; must satisfy 2^SCORE_W-1 >= MAX_ROUNDS.
- RND_W, 4, width of the round counter; must satisfy 2^RND_W-1 >= MAX_ROUNDS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins (or restarts) a match.
- move1  in  2  player 1 move: 00 rock, 01 paper, 10 scissors, 11 invalid.
- move2  in  2  player 2 move, same encoding.
- move_valid  in  1  move1/move2 are both committed this cycle.
- move_ready  out  1  block accepts a move pair this cycle.
- round_result  out  2  last round outcome: 00 none, 01 P1 win, 10 P2 win, 11 tie.
- round_valid  out  1  one-cycle pulse when round_result/scores update.
- move_err  out  1  one-cycle pulse when an accepted pair contained 11.
- score1  out  SCORE_W  player 1 round wins.
- score2  out  SCORE_W  player 2 round wins.
- ties  out  SCORE_W  tied rounds.
- round_cnt  out  RND_W  rounds judged (ties included, errors excluded).
- busy  out  1  match in progress (WAIT_MOVE or RESOLVE).
- match_done  out  1  level, high in DONE.
- winner  out  2  match winner, same encoding as round_result; 00 until DONE.

Behaviour:
- Reset: state IDLE. All counters 0, round_result=00, winner=00. round_valid, move_err, busy, match_done and move_ready are all 0.
- States: IDLE, WAIT_MOVE, RESOLVE, DONE.
- IDLE: move_ready=0. On start, clear all counters, round_result and winner, then go to WAIT_MOVE.
- WAIT_MOVE: move_ready=1. A handshake is move_valid & move_ready; it registers move1/move2 and goes to RESOLVE. Without move_valid, stay.
- RESOLVE (exactly one cycle, move_ready=0): judge the registered pair.
  - Invalid pair (either move 11): pulse move_err; no counter, round_result or round_valid change; return to WAIT_MOVE.
  - Valid pair: update round_result, increment the matching counter and round_cnt, pulse round_valid. All of these are visible the cycle after RESOLVE.
- Latency: handshake cycle N -> round_valid and updated counters at cycle N+2. Next move_ready at N+2 unless the match ends.
- End condition, evaluated on post-increment values in RESOLVE:
  - score1==WIN_TARGET -> winner=01.
  - score2==WIN_TARGET -> winner=10.
  - Otherwise round_cnt==MAX_ROUNDS -> winner is the higher score, or 11 if scores are equal.
  - When any condition fires, go to DONE with winner valid on the same cycle as the final round_valid. Otherwise go to WAIT_MOVE.
- DONE: match_done=1, busy=0, move_ready=0. All outputs hold until start, which clears and enters WAIT_MOVE.
- start in any state (including mid-round RESOLVE) aborts the current match and behaves as from IDLE. Any in-flight pair is discarded: no round_valid, no move_err.
- start and move_valid in the same cycle: start wins and the move is not accepted.
- rst has priority over start.
- Counters never wrap. This is guaranteed by the parameter constraints and the end condition; an assertion checks it.

Decomposition:
- rps_pkg holds:
  - move encodings ROCK/PAPER/SCISSORS/INVALID;
  - result encodings NONE/P1WIN/P2WIN/TIE;
  - the state enum.
- One sub-module, rps_judge: purely combinational. Inputs move1, move2; outputs a 2-bit result (NONE when either move is invalid). Instantiated once in RESOLVE's datapath.

Test Plan:
- Reset, then start; P1 plays paper vs rock three times -> round_valid pulses at N+2 each round. score1 goes 1,2,3. On the third round, winner=01, match_done=1, move_ready=0, round_cnt=3.
- 9 consecutive rock/rock rounds (defaults) -> ties=9, round_cnt=9, winner=11 on round 9, score1=score2=0.
- Mixed sequence to round 9 with P1 on 2, P2 on 1, ties 6 -> winner=01 on round 9 without either player reaching 3.
- Pair move1=11, move2=00 -> move_err pulse, round_valid stays 0, all counters unchanged, move_ready reasserts two cycles after handshake.
- start asserted in the RESOLVE cycle with score1=2 -> counters cleared to 0, no round_valid, WAIT_MOVE next cycle. The same cycle as move_valid -> move not taken.
- rst asserted mid-match with score2=2 -> next cycle all outputs at reset values, state IDLE, move_ready=0 until start.
